wave_seq_ctrl: RTL
==================

# wave_seq_ctrl

Sequencing controller for the waveform lookup tables (sawtooth and sibling LUTs). It owns a phase accumulator that drives the shared 8-bit LUT address `count` and the 2-bit waveform select `sel`. It captures the selected LUT output into a registered sample stream with valid/ready backpressure toward the DAC interface. Waveform and frequency changes are applied only at accumulator wrap, so a waveform switch never occurs mid-period.

## Interface
- `ACC_W`, default 16: phase accumulator width; must be ≥ 8. The LUT address is `acc[ACC_W-1:ACC_W-8]`.
- `clk` in 1: single clock for all state.
- `rst` in 1: reset, asynchronous and active-high.
- `cfg_valid` in 1: new configuration offered.
- `cfg_ready` out 1: configuration accepted on any cycle where `cfg_valid & cfg_ready`.
- `cfg_sel` in 2: waveform select to load (11 = sawtooth).
- `cfg_ftw` in ACC_W: frequency tuning word, added to the accumulator once per emitted sample.
- `run` in 1: level enable for sample generation.
- `count` out 8: LUT address.
- `sel` out 2: active waveform select, driven to the LUTs.
- `lut_phase` in 8: combinational LUT output for (`count`, `sel`). Non-selected LUTs output 0; this input is the OR of all LUT outputs.
- `smp_valid` out 1, `smp_ready` in 1, `smp_data` out 8: sample stream.
- `wrap` out 1: one-cycle pulse on the accumulator carry-out.

## Operation
- Registers:
  - `acc` (ACC_W bits), `act_sel`/`act_ftw` (active configuration).
  - `pend_sel`/`pend_ftw` plus a `pend` flag.
  - The sample register and the state register.
- Outputs: `count` = top 8 bits of `acc`; `sel` = `act_sel`.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `acc` is held at 0.
  - `cfg_ready` = 1; an accepted configuration loads `act_*` directly in the same edge.
  - Go to RUN when `run` = 1.
- RUN:
  - A step occurs when the sample slot is free (`!smp_valid | smp_ready`). On a step:
    - `smp_data <= lut_phase`, `smp_valid <= 1`.
    - `acc <= acc + act_ftw`, modulo 2^ACC_W; the carry-out sets `wrap` for one cycle.
  - No step otherwise: `acc`, `count`, and the sample are all held.
  - If the slot is free but no step is taken (DRAIN), `smp_valid` clears on the handshake.
- Configuration in RUN:
  - `cfg_ready` = `!pend`. An accepted configuration loads `pend_*` and sets `pend`.
  - `pend_*` is copied to `act_*` and `pend` is cleared on the same edge as a step that produces a carry-out.
  - If `act_ftw` = 0, no wrap can occur, so the pending configuration is applied on the next cycle regardless of step.
  - The next step after the apply uses the new `sel`/`ftw`. `acc` is not cleared.
- `run` falling in RUN moves to DRAIN.
- DRAIN:
  - No steps.
  - Wait until `smp_valid` = 0, then enter IDLE with `acc` <= 0.
  - A pending configuration is applied on entry to IDLE.
  - `cfg_ready` = 0 in DRAIN.
- `run` rising in DRAIN has no effect until IDLE is reached.
- Simultaneous `cfg_valid` accept and wrap in RUN: the apply uses the *previously* pending values. The new configuration becomes pending and waits for the next wrap.

## Timing
- Reset values (asynchronous): state IDLE, `acc` = 0, `count` = 0, `sel` = 00, `act_ftw` = 0, `pend` = 0, `smp_valid` = 0, `smp_data` = 0, `wrap` = 0, `cfg_ready` = 1.
- `rst` mid-operation aborts immediately; an in-flight sample and any pending configuration are discarded.
- IDLE→RUN takes one cycle. The first step occurs in the first RUN cycle, capturing `lut_phase` for `count` = 0.
- Sample latency: `smp_data` at the cycle after a step equals the LUT value of the `count`/`sel` present during the step cycle.
- With `smp_ready` tied high, one sample is produced per cycle.
- `smp_data`/`smp_valid` are stable while `smp_valid & !smp_ready`.
- `wrap` is registered. It is high in the cycle after the wrapping step, aligned with the first `count` of the new period.
- All outputs are registered except `cfg_ready`, which is a decode of state and `pend`.

## Test plan
- **Sawtooth ramp:** ACC_W = 16, configure `sel` = 11, `ftw` = 0x0100, `run` = 1, `smp_ready` = 1.
  - `smp_data` = 0, 1, 2, … 255, 0.
  - `wrap` pulses once every 256 samples, when `count` returns to 0.
- **Backpressure:** same setup, drop `smp_ready` for 3 cycles at `smp_data` = 0x10.
  - `smp_data` is held at 0x10 and `count` is held at 0x11.
  - The stream resumes with 0x11, with no gaps and no duplicates.
- **Mid-run reconfiguration:** at `count` = 0x40, offer `sel` = 01, `ftw` = 0x0200.
  - `cfg_ready` drops the cycle after acceptance.
  - `sel` stays 11 until the wrap, becomes 01 on the wrap, and `count` then steps by 2.
  - `cfg_ready` returns to 1.
- **Zero FTW:** run with `ftw` = 0.
  - `count` stays at 0.
  - A new configuration with `ftw` = 0x0100 is applied within one cycle.
- **Stop and drain:** deassert `run` with `smp_valid` = 1 and `smp_ready` = 0 for 2 cycles.
  - The state stays in DRAIN and `cfg_ready` = 0.
  - After the handshake: IDLE, `count` = 0, `smp_valid` = 0.
- **Asynchronous reset mid-run:** assert `rst` between clock edges with `count` = 0x80.
  - All outputs go to their reset values before the next edge.
  - After release with `run` = 1, the ramp restarts from 0 with `sel` = 00.

Source files
------------

// File: rtl/wave_seq_ctrl.sv
// Waveform sequencing controller: phase accumulator driving the LUT address and select, with registered sample capture.
// Latency: smp_data carries the LUT value of the step cycle one cycle later; wrap is registered alongside it.
// Backpressure: a step happens only when the sample slot is free; while smp_valid & !smp_ready, acc and the sample hold.
//
// Ports:
//   clk, rst              - clock; asynchronous active-high reset
//   cfg_valid/cfg_ready   - configuration handshake (cfg_sel, cfg_ftw)
//   run                   - level enable for sample generation
//   count, sel            - LUT address (acc top byte) and active waveform select
//   lut_phase             - combinational LUT output for (count, sel)
//   smp_valid/ready/data  - sample stream toward the DAC interface
//   wrap                  - one-cycle pulse aligned with the first count of a new period
module wave_seq_ctrl #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_sel,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic             run,
    output logic [7:0]       count,
    output logic [1:0]       sel,
    input  logic [7:0]       lut_phase,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [7:0]       smp_data,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [1:0]       act_sel;
    logic [ACC_W-1:0] act_ftw;
    logic [1:0]       pend_sel;
    logic [ACC_W-1:0] pend_ftw;
    logic             pend;

    logic [ACC_W:0]   acc_sum;
    logic             slot_free;
    logic             cfg_acc;
    logic             run_apply;

    assign count     = acc[ACC_W-1 -: 8];
    assign sel       = act_sel;
    assign cfg_ready = (state == IDLE) || ((state == RUN) && !pend);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign slot_free = !smp_valid || smp_ready;

    // Extra MSB captures the carry-out that marks the end of a period.
    assign acc_sum = {1'b0, acc} + {1'b0, act_ftw};

    // Pending config is applied on a wrapping step; with a zero tuning word
    // no wrap can ever happen, so it is applied straight away instead.
    assign run_apply = pend &&
                       ((run && slot_free && acc_sum[ACC_W]) || (act_ftw == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            act_sel   <= 2'b00;
            act_ftw   <= '0;
            pend_sel  <= 2'b00;
            pend_ftw  <= '0;
            pend      <= 1'b0;
            smp_valid <= 1'b0;
            smp_data  <= 8'h00;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    acc <= '0;
                    if (cfg_acc) begin
                        act_sel <= cfg_sel;
                        act_ftw <= cfg_ftw;
                    end
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // No further steps; let an outstanding sample drain.
                        state <= DRAIN;
                        if (smp_ready) begin
                            smp_valid <= 1'b0;
                        end
                    end else if (slot_free) begin
                        smp_data  <= lut_phase;
                        smp_valid <= 1'b1;
                        acc       <= acc_sum[ACC_W-1:0];
                        wrap      <= acc_sum[ACC_W];
                    end
                    if (run_apply) begin
                        act_sel <= pend_sel;
                        act_ftw <= pend_ftw;
                        pend    <= 1'b0;
                    end
                    // Accept only happens with pend clear, so it never races the apply.
                    if (cfg_acc) begin
                        pend_sel <= cfg_sel;
                        pend_ftw <= cfg_ftw;
                        pend     <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (smp_valid) begin
                        if (smp_ready) begin
                            smp_valid <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        acc   <= '0;
                        if (pend) begin
                            act_sel <= pend_sel;
                            act_ftw <= pend_ftw;
                            pend    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
